// File: rtl/alu_multicycle.sv
// Execute ALU for the multicycle core: single-cycle base integer ops plus
// iterative shift-add multiply and restoring divide, behind valid/ready handshakes.
module alu_multicycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] num1,
  input  logic [XLEN-1:0] num2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_XOR    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_AND    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLL    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SRA    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_EQ     = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [SHW:0]      count_reg, count_next;
  logic [4:0]        op_reg, op_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0]   opb_reg, opb_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic              dz_reg, dz_next;
  logic [XLEN-1:0]   res_reg, res_next;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   quick_res;
  logic              is_iter, a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] step, mul_val;
  logic [XLEN-1:0]   quo, rem, fin_res;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == BUSY);
  assign res       = res_reg;

  assign shamt = num2[SHW-1:0];

  always_comb begin
    quick_res = '0;
    case (aluop)
      OP_ADD:  quick_res = num1 + num2;
      OP_SUB:  quick_res = num1 - num2;
      OP_XOR:  quick_res = num1 ^ num2;
      OP_OR:   quick_res = num1 | num2;
      OP_AND:  quick_res = num1 & num2;
      OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(num1) < $signed(num2))};
      OP_SLL:  quick_res = num1 << shamt;
      OP_SRL:  quick_res = num1 >> shamt;
      OP_SRA:  quick_res = $signed(num1) >>> shamt;
      OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (num1 < num2)};
      OP_EQ:   quick_res = {{(XLEN-1){1'b0}}, (num1 == num2)};
      default: quick_res = '0;
    endcase
  end

  // Operands are reduced to magnitudes at accept; signs are reapplied on the last step.
  assign is_iter = (aluop >= OP_MUL) && (aluop <= OP_REMU);
  assign a_sgn   = (aluop == OP_MUL) || (aluop == OP_MULH) || (aluop == OP_MULHSU) ||
                   (aluop == OP_DIV) || (aluop == OP_REM);
  assign b_sgn   = (aluop == OP_MUL) || (aluop == OP_MULH) ||
                   (aluop == OP_DIV) || (aluop == OP_REM);
  assign sa      = a_sgn & num1[XLEN-1];
  assign sb      = b_sgn & num2[XLEN-1];
  assign mag_a   = sa ? -num1 : num1;
  assign mag_b   = sb ? -num2 : num2;

  // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
  assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_reg};

  always_comb begin
    step = {mul_sum, acc_reg[XLEN-1:1]};
    if (op_reg >= OP_DIV) begin
      if (div_diff[XLEN])
        step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
      else
        step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end
  end

  assign mul_val = neg_q_reg ? -step : step;
  assign quo     = step[XLEN-1:0];
  assign rem     = step[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = '0;
    case (op_reg)
      OP_MUL:                       fin_res = mul_val[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = mul_val[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = dz_reg ? '1 : (neg_q_reg ? -quo : quo);
      OP_REM, OP_REMU:              fin_res = neg_r_reg ? -rem : rem;
      default:                      fin_res = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    op_next    = op_reg;
    acc_next   = acc_reg;
    opb_next   = opb_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    dz_next    = dz_reg;
    res_next   = res_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next = aluop;
          if (is_iter) begin
            state_next = BUSY;
            count_next = CNT_INIT;
            acc_next   = {{XLEN{1'b0}}, mag_a};
            opb_next   = mag_b;
            neg_q_next = sa ^ sb;
            neg_r_next = sa;
            dz_next    = (num2 == '0);
          end else begin
            state_next = DONE;
            res_next   = quick_res;
          end
        end
      end
      BUSY: begin
        acc_next   = step;
        count_next = count_reg - CNT_ONE;
        if (count_reg == CNT_ONE) begin
          state_next = DONE;
          res_next   = fin_res;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over any accept or handshake in the same cycle.
    if (flush) begin
      state_next = IDLE;
      count_next = '0;
      res_next   = res_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      op_reg    <= '0;
      acc_reg   <= '0;
      opb_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      acc_reg   <= acc_next;
      opb_reg   <= opb_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      dz_reg    <= dz_next;
      res_reg   <= res_next;
    end
  end
endmodule
